// File: rtl/tmds_pattern_scheduler.sv
// TMDS lane scheduler: loads one 10-bit symbol per lane per word and serialises it LSB-first.
// Optional blue-lane single-bit error injection is enabled with `define TMDS_ERR_INJECT_EN.
module tmds_pattern_scheduler #(
  parameter logic        C_ddr       = 1'b1,
  parameter logic [9:0]  P_R         = 10'b1100110011,
  parameter logic [9:0]  P_G         = 10'b0011001100,
  parameter logic [9:0]  P_B         = 10'b0101010101,
  parameter int unsigned GUARD_WORDS = 2
) (
  input  logic       clk_shift,
  input  logic       resetn,
  input  logic       enable,
  input  logic       mode_req,
  input  logic [1:0] mode_sel,
`ifdef TMDS_ERR_INJECT_EN
  input  logic       err_inject,
`endif
  output logic       mode_ack,
  output logic [1:0] active_mode,
  output logic       busy,
  output logic       word_strobe,
  output logic [1:0] out_clock,
  output logic [1:0] out_red,
  output logic [1:0] out_green,
  output logic [1:0] out_blue
);

  // state    | meaning
  // S_OFF    | idle, lanes quiet, wcnt parked at 0
  // S_RUN    | emitting active_mode symbols
  // S_SWITCH | finishing current word, then GUARD_WORDS of C0, then new mode
  typedef enum logic [1:0] {S_OFF = 2'd0, S_RUN = 2'd1, S_SWITCH = 2'd2} state_e;

  localparam int unsigned TICKS   = C_ddr ? 5 : 10;
  localparam int unsigned SHIFT   = C_ddr ? 2 : 1;
  localparam logic [9:0]  CLK_SYM = 10'b0000011111;
  localparam logic [9:0]  C0_SYM  = 10'b1101010100;

  state_e     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d, gcnt_q, gcnt_d, widx_q, widx_d;
  logic [1:0] cidx_q, cidx_d, mode_q, mode_d, pend_q, pend_d;
  logic [9:0] lfsr_q, lfsr_d;
  logic [9:0] sr_c_q, sr_c_d, sr_r_q, sr_r_d, sr_g_q, sr_g_d, sr_b_q, sr_b_d;
  logic       strobe_q, strobe_d, ack_q, ack_d;

  logic       load, apply, guard, stop, wrap, inject;
  logic [1:0] new_mode, sym_mode, cur_cidx;
  logic [3:0] cur_widx;
  logic [9:0] cur_lfsr, rev, sym_r, sym_g, sym_b, tok;

`ifdef TMDS_ERR_INJECT_EN
  // One-shot: armed by any high sample, consumed by the next load.
  logic arm_q;
  always_ff @(posedge clk_shift or negedge resetn) begin
    if (!resetn)   arm_q <= 1'b0;
    else if (load) arm_q <= arm_q ? 1'b0 : err_inject;
    else           arm_q <= arm_q | err_inject;
  end
  assign inject = arm_q;
`else
  assign inject = 1'b0;
`endif

  always_ff @(posedge clk_shift or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_OFF;
      wcnt_q   <= '0;
      gcnt_q   <= '0;
      widx_q   <= '0;
      cidx_q   <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      lfsr_q   <= 10'h3FF;
      sr_c_q   <= '0;
      sr_r_q   <= '0;
      sr_g_q   <= '0;
      sr_b_q   <= '0;
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      gcnt_q   <= gcnt_d;
      widx_q   <= widx_d;
      cidx_q   <= cidx_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      lfsr_q   <= lfsr_d;
      sr_c_q   <= sr_c_d;
      sr_r_q   <= sr_r_d;
      sr_g_q   <= sr_g_d;
      sr_b_q   <= sr_b_d;
      strobe_q <= strobe_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    gcnt_d   = gcnt_q;
    widx_d   = widx_q;
    cidx_d   = cidx_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    lfsr_d   = lfsr_q;
    sr_c_d   = sr_c_q;
    sr_r_d   = sr_r_q;
    sr_g_d   = sr_g_q;
    sr_b_d   = sr_b_q;
    strobe_d = 1'b0;
    ack_d    = 1'b0;
    load     = 1'b0;
    apply    = 1'b0;
    guard    = 1'b0;
    stop     = 1'b0;
    wrap     = (wcnt_q == 4'(TICKS - 1));

    unique case (state_q)
      S_OFF: begin
        if (mode_req && !ack_q) begin
          apply = 1'b1;
          ack_d = 1'b1;
        end
        if (enable) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (wrap && !enable) begin
          stop    = 1'b1;
          state_d = S_OFF;
        end else begin
          load = wrap;
          if (mode_req && !ack_q) begin
            pend_d  = mode_sel;
            gcnt_d  = '0;
            state_d = S_SWITCH;
          end
        end
      end
      S_SWITCH: begin
        if (wrap) begin
          load = 1'b1;
          if (gcnt_q == 4'(GUARD_WORDS)) begin
            apply   = 1'b1;
            ack_d   = 1'b1;
            state_d = S_RUN;
          end else begin
            guard  = 1'b1;
            gcnt_d = gcnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_OFF;
    endcase

    // A mode change restarts the pattern from index 0 / LFSR seed on its first word.
    new_mode = (state_q == S_OFF) ? mode_sel : pend_q;
    sym_mode = apply ? new_mode : mode_q;
    cur_cidx = apply ? 2'd0 : cidx_q;
    cur_widx = apply ? 4'd0 : widx_q;
    cur_lfsr = apply ? 10'h3FF : lfsr_q;

    rev = '0;
    for (int i = 0; i < 10; i++) rev[i] = cur_lfsr[9-i];

    unique case (cur_cidx)
      2'd0:    tok = 10'b1101010100;
      2'd1:    tok = 10'b0010101011;
      2'd2:    tok = 10'b0101010100;
      default: tok = 10'b1010101011;
    endcase

    unique case (sym_mode)
      2'd0: begin
        sym_r = P_R;
        sym_g = P_G;
        sym_b = P_B;
      end
      2'd1: begin
        sym_r = tok;
        sym_g = tok;
        sym_b = tok;
      end
      2'd2: begin
        sym_r = 10'd1 << cur_widx;
        sym_g = 10'd1 << cur_widx;
        sym_b = 10'd1 << cur_widx;
      end
      default: begin
        sym_r = rev;
        sym_g = ~cur_lfsr;
        sym_b = cur_lfsr;
      end
    endcase
    if (guard) begin
      sym_r = C0_SYM;
      sym_g = C0_SYM;
      sym_b = C0_SYM;
    end

    if (apply) begin
      mode_d = new_mode;
      cidx_d = '0;
      widx_d = '0;
      lfsr_d = 10'h3FF;
    end

    if (load) begin
      sr_c_d   = CLK_SYM;
      sr_r_d   = sym_r;
      sr_g_d   = sym_g;
      sr_b_d   = sym_b ^ {9'b0, inject};
      strobe_d = 1'b1;
      wcnt_d   = '0;
      if (!guard) begin
        cidx_d = cur_cidx + 2'd1;
        widx_d = (cur_widx == 4'd9) ? 4'd0 : cur_widx + 4'd1;
        lfsr_d = {cur_lfsr[8:0], cur_lfsr[9] ^ cur_lfsr[6]};
      end
    end else if (stop) begin
      sr_c_d = '0;
      sr_r_d = '0;
      sr_g_d = '0;
      sr_b_d = '0;
      wcnt_d = '0;
    end else if (state_q != S_OFF) begin
      sr_c_d = sr_c_q >> SHIFT;
      sr_r_d = sr_r_q >> SHIFT;
      sr_g_d = sr_g_q >> SHIFT;
      sr_b_d = sr_b_q >> SHIFT;
      wcnt_d = wcnt_q + 4'd1;
    end
  end

  always_comb begin
    busy        = (state_q == S_SWITCH);
    word_strobe = strobe_q;
    mode_ack    = ack_q;
    active_mode = mode_q;
    out_clock   = C_ddr ? sr_c_q[1:0] : {1'b0, sr_c_q[0]};
    out_red     = C_ddr ? sr_r_q[1:0] : {1'b0, sr_r_q[0]};
    out_green   = C_ddr ? sr_g_q[1:0] : {1'b0, sr_g_q[0]};
    out_blue    = C_ddr ? sr_b_q[1:0] : {1'b0, sr_b_q[0]};
  end

endmodule

// File: tb/tb_tmds_pattern_scheduler.sv
// Bench for tmds_pattern_scheduler: DDR instance checked word-by-word against a
// scoreboard of expected symbols, plus a small SDR instance for bit order and period.
module tb_tmds_pattern_scheduler;

  typedef struct packed {
    logic [9:0] c;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } word_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0, mode_req = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       ack, busy, ws;
  logic [1:0] am, oc, or_, og, ob;

  logic       en_s = 1'b0, req_s = 1'b0;
  logic [1:0] sel_s = 2'd0;
  logic       ack_s, busy_s, ws_s;
  logic [1:0] am_s, oc_s, or_s, og_s, ob_s;

  int n_chk = 0, n_pass = 0;
  word_t sb[$];
  int m_idx;
  logic [9:0] m_lfsr;
  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  always #5 clk = ~clk;

  tmds_pattern_scheduler #(.C_ddr(1'b1)) u_ddr (
    .clk_shift(clk), .resetn(resetn), .enable(enable), .mode_req(mode_req),
    .mode_sel(mode_sel), .mode_ack(ack), .active_mode(am), .busy(busy),
    .word_strobe(ws), .out_clock(oc), .out_red(or_), .out_green(og), .out_blue(ob));

  tmds_pattern_scheduler #(.C_ddr(1'b0)) u_sdr (
    .clk_shift(clk), .resetn(resetn), .enable(en_s), .mode_req(req_s),
    .mode_sel(sel_s), .mode_ack(ack_s), .active_mode(am_s), .busy(busy_s),
    .word_strobe(ws_s), .out_clock(oc_s), .out_red(or_s), .out_green(og_s), .out_blue(ob_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] step_lfsr(input logic [9:0] l);
    return {l[8:0], l[9] ^ l[6]};
  endfunction

  task automatic push_mode(input int m, input int n);
    word_t w;
    m_idx  = 0;
    m_lfsr = 10'h3FF;
    repeat (n) begin
      w.c = 10'b0000011111;
      case (m)
        0: begin w.r = 10'b1100110011; w.g = 10'b0011001100; w.b = 10'b0101010101; end
        1: begin w.r = tok[m_idx % 4]; w.g = w.r; w.b = w.r; end
        2: begin w.r = 10'd1 << (m_idx % 10); w.g = w.r; w.b = w.r; end
        default: begin
          w.b = m_lfsr;
          w.g = ~m_lfsr;
          for (int i = 0; i < 10; i++) w.r[i] = m_lfsr[9-i];
        end
      endcase
      sb.push_back(w);
      m_idx++;
      m_lfsr = step_lfsr(m_lfsr);
    end
  endtask

  task automatic push_guard();
    word_t w;
    w.c = 10'b0000011111;
    w.r = 10'b1101010100;
    w.g = w.r;
    w.b = w.r;
    repeat (2) sb.push_back(w);
  endtask

  task automatic wait_strobe(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      cyc = i;
      if (ws) break;
    end
    if (!ws) check("strobe_timeout", ws, 1);
  endtask

  // Requests mode m at a word start, expects 2 guard words then n words of m.
  // Returns on the strobe of the n-th new-mode word.
  task automatic do_switch(input int m, input int n);
    int cyc;
    mode_req = 1'b1;
    mode_sel = 2'(m);
    push_guard();
    push_mode(m, n);
    @(negedge clk);
    check("busy_set", busy, 1);
    for (int i = 0; i < 60; i++) begin
      if (ack) break;
      @(negedge clk);
    end
    check("ack_seen", ack, 1);
    check("ack_with_strobe", ws, 1);
    check("active_mode_new", am, m);
    check("busy_clear", busy, 0);
    mode_req = 1'b0;
    repeat (n - 1) wait_strobe(cyc);
  endtask

  // Word monitor: reassembles DDR lane bits starting at each strobe.
  int ph = -1;
  logic [9:0] cc, cr, cg, cb;
  always @(negedge clk) begin
    word_t e;
    if (!resetn) ph = -1;
    else begin
      if (ws) ph = 0;
      if (ph >= 0) begin
        cc[2*ph +: 2] = oc;
        cr[2*ph +: 2] = or_;
        cg[2*ph +: 2] = og;
        cb[2*ph +: 2] = ob;
        ph++;
        if (ph == 5) begin
          ph = -1;
          if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
          else begin
            e = sb.pop_front();
            check("word_clock", cc, e.c);
            check("word_red", cr, e.r);
            check("word_green", cg, e.g);
            check("word_blue", cb, e.b);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nstr;
    logic [9:0] pr;
    pr = 10'b1100110011;

    repeat (3) @(negedge clk);
    check("rst_outs", {oc, or_, og, ob}, 0);
    check("rst_strobe", ws, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_mode", am, 0);
    resetn = 1'b1;
    @(negedge clk);

    // SDR: LSB-first single bit lane, 10-cycle word.
    en_s = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("sdr_strobe", ws_s, (i == 0) ? 1 : 0);
      check("sdr_red_hi", or_s[1], 0);
      check("sdr_red_bit", or_s[0], pr[i]);
      @(negedge clk);
    end
    check("sdr_period", ws_s, 1);
    en_s = 1'b0;
    repeat (12) @(negedge clk);
    check("sdr_off", {or_s, ob_s, ws_s}, 0);

    // DDR FIXED start.
    push_mode(0, 3);
    enable = 1'b1;
    @(negedge clk);
    check("first_strobe", ws, 1);
    check("first_blue", ob, 2'b01);
    check("first_clock", oc, 2'b11);
    wait_strobe(cyc);
    check("strobe_period", cyc, 5);
    wait_strobe(cyc);
    check("strobe_period", cyc, 5);

    do_switch(2, 4);
    do_switch(3, 3);

    // Drop enable mid-word at wcnt=2.
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("off_outs", {oc, or_, og, ob}, 0);
    check("off_strobe", ws, 0);
    nstr = 0;
    repeat (15) begin
      @(negedge clk);
      if (ws) nstr++;
    end
    check("no_more_strobes", nstr, 0);
    check("off_keeps_mode", am, 3);

    // Mode request while OFF applies immediately.
    mode_req = 1'b1;
    mode_sel = 2'd1;
    @(negedge clk);
    check("off_ack", ack, 1);
    check("off_mode", am, 1);
    check("off_ack_no_strobe", ws, 0);
    mode_req = 1'b0;
    @(negedge clk);
    check("off_ack_pulse", ack, 0);

    push_mode(1, 3);
    enable = 1'b1;
    @(negedge clk);
    check("ctrl_strobe", ws, 1);
    wait_strobe(cyc);
    wait_strobe(cyc);

    // Reset in the middle of the guard sequence.
    mode_req = 1'b1;
    mode_sel = 2'd0;
    push_guard();
    @(negedge clk);
    check("busy_before_rst", busy, 1);
    wait_strobe(cyc);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    mode_req = 1'b0;
    enable = 1'b0;
    #1;
    check("async_outs", {oc, or_, og, ob}, 0);
    check("async_mode", am, 0);
    check("async_busy", busy, 0);
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_no_ack", ack, 0);
    end
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_ack", ack, 0);

    push_mode(0, 2);
    enable = 1'b1;
    @(negedge clk);
    check("resume_strobe", ws, 1);
    check("resume_mode", am, 0);
    wait_strobe(cyc);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    check("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
